pin_stream_tx: RTL

Byte-stream transmitter that carries bytes from on-chip logic out to the off-chip host over the TinyTapeout pins. It uses a two-phase (toggle) req/ack handshake. Internal producers push bytes through a valid/ready port into a small FIFO. The block presents each byte on `out_data` and toggles `out_req`, then waits for the host to mirror the toggle on `out_ack`. It sits between the user logic and `uo_out`/`uio_in` inside the top-level `tt_um_*` wrapper.

---
 rtl/pin_stream_tx_if.sv | 40 ++++
 rtl/pin_stream_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pin_stream_tx_if.sv
// pin_stream_tx_if: producer-side valid/ready signals and host-side toggle
// handshake pins of pin_stream_tx, bundled for port connection.
// The modport "master" is the transmitter's view; "slave" is the view of
// whatever drives the producer and host sides.
// Optional macro PIN_TX_PARITY_EN adds the out_par pin.
interface pin_stream_tx_if #(
  parameter int DEPTH = 4
) ();
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               out_data;
  logic                     out_req;
  logic                     out_ack;
  logic                     busy;
  logic [$clog2(DEPTH):0]   level;
`ifdef PIN_TX_PARITY_EN
  logic                     out_par;

  modport master (
    input  in_data, in_valid, out_ack,
    output in_ready, out_data, out_req, busy, level, out_par
  );

  modport slave (
    output in_data, in_valid, out_ack,
    input  in_ready, out_data, out_req, busy, level, out_par
  );
`else
  modport master (
    input  in_data, in_valid, out_ack,
    output in_ready, out_data, out_req, busy, level
  );

  modport slave (
    output in_data, in_valid, out_ack,
    input  in_ready, out_data, out_req, busy, level
  );
`endif
endinterface

// File: rtl/pin_stream_tx.sv
// pin_stream_tx: byte FIFO feeding a two-phase (toggle) req/ack transmitter
// toward an off-chip host. A byte stays in the FIFO (and in level) until the
// host mirrors the out_req toggle on out_ack; only then is it popped.
// Optional macro PIN_TX_PARITY_EN adds a registered even-parity bit out_par.
module pin_stream_tx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pin_stream_tx_if.master   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          mem [DEPTH];
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [7:0]          out_data_reg;
  logic                out_req_reg;
  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                ack_s;
  logic                full, empty, push, launch, pop;
`ifdef PIN_TX_PARITY_EN
  logic                out_par_reg;
`endif

  // Synchronizer chain: stage 0 takes the asynchronous host toggle,
  // each later stage takes the one before it.
  assign sync_next[0] = bus.out_ack;
  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate
  assign ack_s = sync_reg[SYNC_STAGES-1];

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  // in_ready depends only on the registered count, so a pop edge cannot
  // open a slot for a push on that same edge.
  assign push  = bus.in_valid && !full;

  // Shift the host acknowledge toggle through the synchronizer.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= sync_next;
  end

  // State register for the launch/complete handshake machine.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Launch when data waits and the host is in phase; complete on match.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty && (ack_s == out_req_reg)) begin
          launch     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (ack_s == out_req_reg) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.in_data;
  end

  // Pointers, occupancy and the registered host-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      out_data_reg <= 8'h00;
      out_req_reg  <= 1'b0;
`ifdef PIN_TX_PARITY_EN
      out_par_reg  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (launch) begin
        out_data_reg <= mem[rd_ptr_reg];
        out_req_reg  <= ~out_req_reg;
`ifdef PIN_TX_PARITY_EN
        out_par_reg  <= ^mem[rd_ptr_reg];
`endif
      end
    end
  end

  assign bus.in_ready = !full;
  assign bus.level    = count_reg;
  assign bus.out_data = out_data_reg;
  assign bus.out_req  = out_req_reg;
  assign bus.busy     = (state_reg == SEND) || !empty;
`ifdef PIN_TX_PARITY_EN
  assign bus.out_par  = out_par_reg;
`endif

endmodule
